regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (we/wa/wdata) between two writeback sources.
//  The sources are the execute/ALU path (ex_*) and the load path (ld_*).

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for a single register-file write port.
// Each source (execute, load) has a one-entry holding register; a registered write stage commits the winner.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            we,
  output logic [4:0]      wa,
  output logic [XLEN-1:0] wdata,
  output logic [31:0]     pend_mask
);

  logic            hold_ex_v_q, hold_ex_v_d;
  logic [4:0]      hold_ex_rd_q, hold_ex_rd_d;
  logic [XLEN-1:0] hold_ex_data_q, hold_ex_data_d;
  logic            hold_ld_v_q, hold_ld_v_d;
  logic [4:0]      hold_ld_rd_q, hold_ld_rd_d;
  logic [XLEN-1:0] hold_ld_data_q, hold_ld_data_d;
  logic            ex_older_q, ex_older_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic grant_ex, grant_ld, same_rd, starved, ex_acc, ld_acc;

  assign same_rd = (hold_ex_rd_q == hold_ld_rd_q);
  assign starved = (starve_cnt_q == 4'(STARVE_LIMIT));

  // Same-rd pairs must commit in acceptance order so the later value survives.
  assign grant_ex = hold_ex_v_q & (!hold_ld_v_q | (same_rd ? ex_older_q : starved));
  assign grant_ld = hold_ld_v_q & !grant_ex;

  assign ex_ready = reset & (!hold_ex_v_q | grant_ex);
  assign ld_ready = reset & (!hold_ld_v_q | grant_ld);

  assign ex_acc = ex_valid & ex_ready & (ex_rd != 5'd0);
  assign ld_acc = ld_valid & ld_ready & (ld_rd != 5'd0);

  always_comb begin
    hold_ex_v_d    = hold_ex_v_q & !grant_ex;
    hold_ex_rd_d   = hold_ex_rd_q;
    hold_ex_data_d = hold_ex_data_q;
    if (ex_acc) begin
      hold_ex_v_d    = 1'b1;
      hold_ex_rd_d   = ex_rd;
      hold_ex_data_d = ex_data;
    end

    hold_ld_v_d    = hold_ld_v_q & !grant_ld;
    hold_ld_rd_d   = hold_ld_rd_q;
    hold_ld_data_d = hold_ld_data_q;
    if (ld_acc) begin
      hold_ld_v_d    = 1'b1;
      hold_ld_rd_d   = ld_rd;
      hold_ld_data_d = ld_data;
    end

    // ex is older unless an ld entry survives this edge while ex is newly loaded.
    ex_older_d = ex_older_q;
    if (ex_acc && ld_acc)
      ex_older_d = 1'b1;
    else if (ex_acc)
      ex_older_d = !(hold_ld_v_q & !grant_ld);
    else if (ld_acc)
      ex_older_d = 1'b1;

    starve_cnt_d = starve_cnt_q;
    if (!hold_ex_v_q || grant_ex)
      starve_cnt_d = 4'd0;
    else if (grant_ld && !starved)
      starve_cnt_d = starve_cnt_q + 4'd1;

    we_d    = grant_ex | grant_ld;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    if (grant_ex) begin
      wa_d    = hold_ex_rd_q;
      wdata_d = hold_ex_data_q;
    end else if (grant_ld) begin
      wa_d    = hold_ld_rd_q;
      wdata_d = hold_ld_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_ex_v_q    <= 1'b0;
      hold_ex_rd_q   <= 5'd0;
      hold_ex_data_q <= '0;
      hold_ld_v_q    <= 1'b0;
      hold_ld_rd_q   <= 5'd0;
      hold_ld_data_q <= '0;
      ex_older_q     <= 1'b0;
      starve_cnt_q   <= 4'd0;
      we_q           <= 1'b0;
      wa_q           <= 5'd0;
      wdata_q        <= '0;
    end else begin
      hold_ex_v_q    <= hold_ex_v_d;
      hold_ex_rd_q   <= hold_ex_rd_d;
      hold_ex_data_q <= hold_ex_data_d;
      hold_ld_v_q    <= hold_ld_v_d;
      hold_ld_rd_q   <= hold_ld_rd_d;
      hold_ld_data_q <= hold_ld_data_d;
      ex_older_q     <= ex_older_d;
      starve_cnt_q   <= starve_cnt_d;
      we_q           <= we_d;
      wa_q           <= wa_d;
      wdata_q        <= wdata_d;
    end
  end

  always_comb begin
    pend_mask = 32'd0;
    if (hold_ex_v_q) pend_mask[hold_ex_rd_q] = 1'b1;
    if (hold_ld_v_q) pend_mask[hold_ld_rd_q] = 1'b1;
    if (we_q)        pend_mask[wa_q]         = 1'b1;
    pend_mask[0] = 1'b0;
    if (!reset) pend_mask = 32'd0;
  end

  assign we    = we_q;
  assign wa    = wa_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with a write-order scoreboard
// fed by the driver and drained by a negedge monitor of the write port.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid, ld_valid;
  logic            ex_ready, ld_ready;
  logic [4:0]      ex_rd, ld_rd;
  logic [XLEN-1:0] ex_data, ld_data;
  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wdata;
  logic [31:0]     pend_mask;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb_q[$];
  logic [XLEN-1:0] rf [32];
  logic sb_en = 1'b1;

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .we(we), .wa(wa), .wdata(wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_en && we) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", {27'd0, wa, wdata}, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("sb_write", {27'd0, wa, wdata}, {27'd0, e});
        rf[wa] = wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int n;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0;
    ex_valid = 1'b0; ld_valid = 1'b0;
    ex_rd = '0; ld_rd = '0; ex_data = '0; ld_data = '0;
    #2;
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pend", pend_mask, 0);
    tick(); tick();
    #2 reset = 1'b1;
    tick();

    // 1: single ex write, latency
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    chk("t1_ex_ready", ex_ready, 1);
    sb_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    ex_valid = 1'b0;
    chk("t1_pend_after_E", pend_mask, 32'h20);
    chk("t1_we_after_E", we, 0);
    tick();
    chk("t1_we_after_E1", we, 1);
    chk("t1_pend_after_E1", pend_mask, 32'h20);
    tick();
    chk("t1_we_after_E2", we, 0);
    chk("t1_pend_after_E2", pend_mask, 0);

    // 2: ex rd3 + ld rd4 together, ex held
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hAAAA0003;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'hBBBB0004;
    sb_q.push_back({5'd4, 32'hBBBB0004});
    sb_q.push_back({5'd3, 32'hAAAA0003});
    tick();
    ld_valid = 1'b0;
    ex_rd = 5'd6; ex_data = 32'hCCCC0006;
    chk("t2_ex_ready_blocked", ex_ready, 0);
    chk("t2_pend", pend_mask, 32'h18);
    tick();
    chk("t2_ex_ready_free", ex_ready, 1);
    chk("t2_wa_first", wa, 4);
    sb_q.push_back({5'd6, 32'hCCCC0006});
    tick();
    ex_valid = 1'b0;
    chk("t2_wa_second", wa, 3);
    tick(); tick();

    // 3: same rd from both, ex older on tie
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'd1;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'd2;
    sb_q.push_back({5'd7, 32'd1});
    sb_q.push_back({5'd7, 32'd2});
    tick();
    ex_valid = 1'b0; ld_valid = 1'b0;
    chk("t3_pend", pend_mask, 32'h80);
    tick(); tick(); tick();
    chk("t3_x7_final", rf[7], 2);

    // 4: starvation, ld streaming distinct rd, ex rd9 waits 3 grants
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'd99;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'd110;
    sb_q.push_back({5'd10, 32'd110});
    sb_q.push_back({5'd11, 32'd111});
    sb_q.push_back({5'd12, 32'd112});
    sb_q.push_back({5'd9,  32'd99});
    sb_q.push_back({5'd13, 32'd113});
    sb_q.push_back({5'd14, 32'd114});
    tick();
    ex_valid = 1'b0;
    stalls = 0;
    for (int r = 11; r <= 14; r++) begin
      ld_rd = 5'(r); ld_data = 32'(100 + r);
      n = 0;
      while (!ld_ready && n < 5) begin
        stalls++; n++;
        tick();
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("t4_ld_stalls", stalls, 1);
    tick(); tick(); tick();
    chk("t4_pend_idle", pend_mask, 0);

    // 5: rd 0 is dropped
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      chk("t5_ex_ready", ex_ready, 1);
      tick();
      chk("t5_we", we, 0);
      chk("t5_pend", pend_mask, 0);
    end
    ex_valid = 1'b0;
    tick();

    // 6: async reset with both entries full and a write in flight
    chk("t6_sb_drained", sb_q.size(), 0);
    sb_en = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'd11;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'd22;
    tick();
    ex_valid = 1'b0;
    ld_rd = 5'd3; ld_data = 32'd33;
    tick();
    ld_valid = 1'b0;
    chk("t6_pend_full", pend_mask, 32'hE);
    chk("t6_we_full", we, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_we", we, 0);
    chk("t6_rst_pend", pend_mask, 0);
    chk("t6_rst_ex_ready", ex_ready, 0);
    chk("t6_rst_ld_ready", ld_ready, 0);
    tick();
    #2 reset = 1'b1;
    tick();
    chk("t6_rel_ex_ready", ex_ready, 1);
    chk("t6_rel_ld_ready", ld_ready, 1);
    chk("t6_rel_we", we, 0);
    tick();
    chk("t6_rel_we2", we, 0);
    chk("t6_rel_pend", pend_mask, 0);
    sb_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
